branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Receiving end of the branch feedback interface. A direct-mapped BTB with 2-bit
//  saturating counters predicts taken/target for the fetch PC each cycle.
//  Resolved-branch feedback from execute trains the table. A registered redirect
//  to fetch is issued on every misprediction.
// PARAMETERS
//  PC_W     16  PC width; equals `PC_SIZE
//  ENTRIES  16  BTB entries; power of two, >=2; IDX_W = $clog2(ENTRIES)
//  CNT_W    16  width of saturating mispredict statistics counter
// PORTS
//  clk              in   1      clock, all state on rising edge
//  rst              in   1      asynchronous reset, active-high
//  fetch_pc         in   PC_W   PC being fetched this cycle
//  pred_taken       out  1      prediction for fetch_pc (combinational)
//  pred_target      out  PC_W   predicted next PC for fetch_pc (combinational)
//  fb_branch        in   1      feedback valid: resolved branch this cycle
//  fb_pc            in   PC_W   PC of resolved branch
//  fb_predict_target in  PC_W   target predicted at fetch
//  fb_feedback_target in PC_W   actual target
//  fb_predict_taken in   1      direction predicted at fetch
//  fb_feedback_taken in  1      actual direction
//  redirect_valid   out  1      one-cycle pulse: fetch must restart at redirect_pc
//  redirect_pc      out  PC_W   correct next PC after mispredicted branch
//  mispredict_cnt   out  CNT_W  saturating count of mispredictions
// BEHAVIOUR
//  Entry = {valid, tag[PC_W-IDX_W], target[PC_W], ctr[2]};
//   idx = pc[IDX_W-1:0], tag = pc[PC_W-1:IDX_W].
//  Reset (async, any time, incl. mid-update): all valid=0, ctr=2'b01,
//   redirect_valid=0, redirect_pc=0, mispredict_cnt=0. Lookups during/after reset miss.
//  Lookup (0 latency): hit = valid[idx] & tag match. pred_taken = hit & ctr[1].
//   pred_target = pred_taken ? target : fetch_pc+1 (PC is word-addressed, wraps mod 2^PC_W).
//  Lookup reads pre-edge state: a same-cycle update to the same idx is not visible
//   until the next cycle.
//  Update, on clock edge when fb_branch=1, entry at fb_pc's idx:
//   - hit & taken: ctr=sat_inc(ctr), target=fb_feedback_target.
//   - hit & not taken: ctr=sat_dec(ctr); target unchanged; entry stays valid.
//   - miss & taken: allocate/overwrite: valid=1, tag, target, ctr=2'b10.
//   - miss & not taken: no change.
//   sat_inc: 11 stays 11; sat_dec: 00 stays 00.
//  Mispredict = fb_branch & (predict_taken != feedback_taken |
//   (feedback_taken & predict_target != feedback_target)).
//  Redirect is registered, 1-cycle latency.
//   - Edge after a mispredict cycle: redirect_valid=1,
//     redirect_pc = fb_feedback_taken ? fb_feedback_target : fb_pc+1.
//   - Otherwise redirect_valid=0; redirect_pc holds its last value.
//  Back-to-back feedback (one per cycle) fully supported; no backpressure.
//  mispredict_cnt increments on each mispredict and saturates at all-ones.
//  fb_* values are ignored when fb_branch=0.
// TESTING
//  1 Reset, fetch_pc=0x0040 -> pred_taken=0, pred_target=0x0041, redirect_valid=0,
//    mispredict_cnt=0.
//  2 Feedback pc=0x0040 taken tgt=0x0100, predicted not-taken
//    -> next cycle redirect_valid=1, redirect_pc=0x0100;
//    fetch 0x0040 -> taken, 0x0100; mispredict_cnt=1.
//  3 Same branch resolved not-taken 3x, pred taken ->
//    ctr 10->01->00->00, redirect_pc=0x0041 each time; then pred_taken=0, entry valid.
//  4 Alias: 0x0050 taken to 0x0200 (ENTRIES=16) evicts 0x0040;
//    fetch 0x0040 -> miss, pred_target=0x0041.
//  5 Feedback and lookup same idx in same cycle -> lookup shows old entry;
//    new entry visible next cycle.
//  6 fetch_pc=0xFFFF miss -> pred_target=0x0000; assert rst mid-stream -> all
//    entries miss, outputs 0 immediately; CNT_W=2 with 5 mispredicts -> cnt=3.

Source files
------------

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, feedback training and registered redirect
module branch_predictor #(
    parameter int PC_W    = 16,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              fb_branch,
    input  logic [PC_W-1:0]   fb_pc,
    input  logic [PC_W-1:0]   fb_predict_target,
    input  logic [PC_W-1:0]   fb_feedback_target,
    input  logic              fb_predict_taken,
    input  logic              fb_feedback_taken,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W;

    logic [ENTRIES-1:0]             valid_q, valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [ENTRIES-1:0][PC_W-1:0]   target_q, target_d;
    logic [ENTRIES-1:0][1:0]        ctr_q, ctr_d;
    logic                           redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]                redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit, mispredict;

    assign f_idx = fetch_pc[IDX_W-1:0];
    assign f_tag = fetch_pc[PC_W-1:IDX_W];
    assign u_idx = fb_pc[IDX_W-1:0];
    assign u_tag = fb_pc[PC_W-1:IDX_W];

    // Zero-latency lookup from the registered table; same-cycle updates are not visible
    always_comb begin
        f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken  = f_hit && ctr_q[f_idx][1];
        pred_target = pred_taken ? target_q[f_idx] : fetch_pc + PC_W'(1);
    end

    // Table training from resolved-branch feedback
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        if (fb_branch) begin
            if (u_hit) begin
                if (fb_feedback_taken) begin
                    if (ctr_q[u_idx] != 2'b11) ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
                    target_d[u_idx] = fb_feedback_target;
                end else if (ctr_q[u_idx] != 2'b00) begin
                    ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
                end
            end else if (fb_feedback_taken) begin
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                target_d[u_idx] = fb_feedback_target;
                ctr_d[u_idx]    = 2'b10;
            end
        end
    end

    // Mispredict detection, redirect target and saturating statistics
    always_comb begin
        mispredict = fb_branch &&
                     ((fb_predict_taken != fb_feedback_taken) ||
                      (fb_feedback_taken && (fb_predict_target != fb_feedback_target)));
        redirect_valid_d = mispredict;
        redirect_pc_d    = redirect_pc_q;
        cnt_d            = cnt_q;
        if (mispredict) begin
            redirect_pc_d = fb_feedback_taken ? fb_feedback_target : fb_pc + PC_W'(1);
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset invalidates every entry and weakly biases counters not-taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q          <= '0;
            tag_q            <= '0;
            target_q         <= '0;
            ctr_q            <= {ENTRIES{2'b01}};
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            cnt_q            <= '0;
        end else begin
            valid_q          <= valid_d;
            tag_q            <= tag_d;
            target_q         <= target_d;
            ctr_q            <= ctr_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            cnt_q            <= cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign mispredict_cnt = cnt_q;

endmodule
